// File: rtl/vpu_pkg.sv
// Shared types for the VPU command dispatcher: the command word and the dispatch FSM states.
package vpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int ADDR_W   = 8;
    localparam int DELAY_W  = 4;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   src0;
        logic [ADDR_W-1:0]   src1;
        logic [ADDR_W-1:0]   src2;
        logic [ADDR_W-1:0]   dst;
        logic [DELAY_W-1:0]  delay;
    } vpu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_CPL
    } dispatch_state_e;

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit occupancy counter.
module vpu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    // Guard both ports so a stray request can never corrupt the pointers.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vpu_cmd_dispatch.sv
// Queues host commands and issues them one at a time to the VPU, returning each tag on completion.
module vpu_cmd_dispatch
    import vpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_valid_i,
    output logic                      host_ready_o,
    input  vpu_cmd_t                  host_cmd_i,
    input  logic [TAG_W-1:0]          host_tag_i,
    output logic                      vpu_req_valid_o,
    input  logic                      vpu_req_ready_i,
    output vpu_cmd_t                  vpu_req_cmd_o,
    input  logic                      vpu_done_i,
    output logic                      cpl_valid_o,
    output logic [TAG_W-1:0]          cpl_tag_o,
    input  logic                      cpl_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int ENTRY_W = $bits(vpu_cmd_t) + TAG_W;

    dispatch_state_e    state_q;
    logic               reqValid_q;
    vpu_cmd_t           cmd_q;
    logic [TAG_W-1:0]   tag_q;
    logic               cplValid_q;
    logic [TAG_W-1:0]   cplTag_q;
    logic               err_q;

    logic [ENTRY_W-1:0] fifoData;
    vpu_cmd_t           fifoCmd;
    logic [TAG_W-1:0]   fifoTag;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               pop;

    vpu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (host_valid_i && host_ready_o),
        .data_i  ({host_cmd_i, host_tag_i}),
        .pop_i   (pop),
        .data_o  (fifoData),
        .count_o (fifo_cnt_o),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign {fifoCmd, fifoTag} = fifoData;

    // The head moves into the issue register from IDLE, or straight from CPL as the completion is taken.
    assign pop = !fifoEmpty &&
                 ((state_q == S_IDLE) || ((state_q == S_CPL) && cpl_ready_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            reqValid_q <= 1'b0;
            cmd_q      <= '0;
            tag_q      <= '0;
            cplValid_q <= 1'b0;
            cplTag_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (vpu_done_i && (state_q != S_WAIT_DONE)) err_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cmd_q      <= fifoCmd;
                        tag_q      <= fifoTag;
                        reqValid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (vpu_req_ready_i) begin
                        reqValid_q <= 1'b0;
                        state_q    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (vpu_done_i) begin
                        cplValid_q <= 1'b1;
                        cplTag_q   <= tag_q;
                        state_q    <= S_CPL;
                    end
                end
                S_CPL: begin
                    if (cpl_ready_i) begin
                        cplValid_q <= 1'b0;
                        if (pop) begin
                            cmd_q      <= fifoCmd;
                            tag_q      <= fifoTag;
                            reqValid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign host_ready_o    = !fifoFull;
    assign vpu_req_valid_o = reqValid_q;
    assign vpu_req_cmd_o   = cmd_q;
    assign cpl_valid_o     = cplValid_q;
    assign cpl_tag_o       = cplTag_q;
    assign err_o           = err_q;
    assign busy_o          = !fifoEmpty || (state_q != S_IDLE);

endmodule

// File: tb/tb_vpu_cmd_dispatch.sv
// Directed scenarios plus a randomized host/VPU exchange checked against an in-order transaction model.
module tb_vpu_cmd_dispatch;
    import vpu_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic                       clk;
    logic                       rst_n;
    logic                       host_valid_i;
    logic                       host_ready_o;
    vpu_cmd_t                   host_cmd_i;
    logic [TAG_W-1:0]           host_tag_i;
    logic                       vpu_req_valid_o;
    logic                       vpu_req_ready_i;
    vpu_cmd_t                   vpu_req_cmd_o;
    logic                       vpu_done_i;
    logic                       cpl_valid_o;
    logic [TAG_W-1:0]           cpl_tag_o;
    logic                       cpl_ready_i;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o;
    logic                       busy_o;
    logic                       err_o;

    vpu_cmd_dispatch #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_valid_i    (host_valid_i),
        .host_ready_o    (host_ready_o),
        .host_cmd_i      (host_cmd_i),
        .host_tag_i      (host_tag_i),
        .vpu_req_valid_o (vpu_req_valid_o),
        .vpu_req_ready_i (vpu_req_ready_i),
        .vpu_req_cmd_o   (vpu_req_cmd_o),
        .vpu_done_i      (vpu_done_i),
        .cpl_valid_o     (cpl_valid_o),
        .cpl_tag_o       (cpl_tag_o),
        .cpl_ready_i     (cpl_ready_i),
        .fifo_cnt_o      (fifo_cnt_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        vpu_cmd_t         cmd;
        logic [TAG_W-1:0] tag;
    } entry_t;

    int     checks;
    int     failures;
    entry_t expQ[$];
    int     pushCnt;
    int     hsCnt;
    int     consCnt;
    int     doneCountdown;
    bit     cplPending;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
            $error("[TB] check %s", name);
        end
    endtask

    function automatic vpu_cmd_t randCmd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(vpu_cmd_t)-1:0];
    endfunction

    task automatic resetModel();
        expQ.delete();
        pushCnt       = 0;
        hsCnt         = 0;
        consCnt       = 0;
        doneCountdown = 0;
        cplPending    = 1'b0;
    endtask

    task automatic applyReset();
        rst_n           = 1'b0;
        host_valid_i    = 1'b0;
        host_cmd_i      = '0;
        host_tag_i      = '0;
        vpu_req_ready_i = 1'b0;
        vpu_done_i      = 1'b0;
        cpl_ready_i     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        resetModel();
    endtask

    task automatic hostPush(input logic [TAG_W-1:0] tag);
        entry_t e;
        e.cmd = randCmd();
        e.tag = tag;
        expQ.push_back(e);
        pushCnt++;
        host_valid_i = 1'b1;
        host_cmd_i   = e.cmd;
        host_tag_i   = e.tag;
        tick();
    endtask

    // One cycle of model-checked traffic: compare outputs with the transaction counts, then drive the next inputs.
    task automatic applyStimulus(input int pushPct, input int readyPct, input int cplPct);
        int     expCnt;
        bit     nextPending;
        entry_t e;
        expCnt = pushCnt - hsCnt - (vpu_req_valid_o ? 1 : 0);
        checkOutput("fifo_cnt_model", fifo_cnt_o, expCnt);
        checkOutput("host_ready_model", host_ready_o, expCnt != FIFO_DEPTH);
        checkOutput("busy_model", busy_o, pushCnt != consCnt);
        checkOutput("cpl_valid_model", cpl_valid_o, cplPending);
        checkOutput("one_outstanding", vpu_req_valid_o && (hsCnt != consCnt || pushCnt <= hsCnt), 1'b0);
        checkOutput("err_clear", err_o, 1'b0);
        if (vpu_req_valid_o && hsCnt < expQ.size())
            checkOutput("req_cmd_order", vpu_req_cmd_o, expQ[hsCnt].cmd);
        if (cpl_valid_o && consCnt < expQ.size())
            checkOutput("cpl_tag_order", cpl_tag_o, expQ[consCnt].tag);

        nextPending = cplPending;
        vpu_done_i  = 1'b0;
        if (doneCountdown > 0) begin
            doneCountdown--;
            if (doneCountdown == 0) begin
                vpu_done_i  = 1'b1;
                nextPending = 1'b1;
            end
        end
        vpu_req_ready_i = ($urandom_range(99) < readyPct);
        if (vpu_req_valid_o && vpu_req_ready_i) begin
            hsCnt++;
            doneCountdown = $urandom_range(4, 1);
        end
        cpl_ready_i = ($urandom_range(99) < cplPct);
        if (cpl_valid_o && cpl_ready_i) begin
            consCnt++;
            nextPending = 1'b0;
        end
        host_cmd_i = randCmd();
        host_tag_i = TAG_W'($urandom);
        if (($urandom_range(99) < pushPct) && host_ready_o) begin
            e.cmd = host_cmd_i;
            e.tag = host_tag_i;
            expQ.push_back(e);
            pushCnt++;
            host_valid_i = 1'b1;
        end else begin
            host_valid_i = !host_ready_o && ($urandom_range(99) < pushPct);
        end
        tick();
        cplPending = nextPending;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && consCnt != pushCnt; i++) applyStimulus(0, 100, 100);
        checkOutput("drain_all_completed", consCnt, pushCnt);
    endtask

    initial begin
        vpu_cmd_t c;
        checks   = 0;
        failures = 0;

        // Single command through an idle block.
        applyReset();
        checkOutput("rst_req_valid", vpu_req_valid_o, 0);
        checkOutput("rst_cpl_valid", cpl_valid_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_req_cmd", vpu_req_cmd_o, 0);
        checkOutput("rst_cpl_tag", cpl_tag_o, 0);
        checkOutput("rst_host_ready", host_ready_o, 1);
        checkOutput("rst_fifo_cnt", fifo_cnt_o, 0);
        vpu_req_ready_i = 1'b1;
        cpl_ready_i     = 1'b1;
        c = randCmd();
        host_valid_i = 1'b1;
        host_cmd_i   = c;
        host_tag_i   = 4'd3;
        tick();
        host_valid_i = 1'b0;
        checkOutput("t1_valid_push_plus1", vpu_req_valid_o, 0);
        tick();
        checkOutput("t1_valid_push_plus2", vpu_req_valid_o, 1);
        checkOutput("t1_cmd", vpu_req_cmd_o, c);
        tick();
        checkOutput("t1_valid_after_hs", vpu_req_valid_o, 0);
        repeat (3) tick();
        checkOutput("t1_no_cpl_before_done", cpl_valid_o, 0);
        vpu_done_i = 1'b1;
        tick();
        vpu_done_i = 1'b0;
        checkOutput("t1_cpl_valid", cpl_valid_o, 1);
        checkOutput("t1_cpl_tag", cpl_tag_o, 3);
        checkOutput("t1_busy_during_cpl", busy_o, 1);
        tick();
        checkOutput("t1_cpl_consumed", cpl_valid_o, 0);
        checkOutput("t1_busy_after", busy_o, 0);
        checkOutput("t1_err", err_o, 0);

        // Fill the queue behind a stalled VPU, then let everything drain in order.
        applyReset();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_host_ready_before_push", host_ready_o, 1);
            hostPush(4'(i));
        end
        host_valid_i = 1'b0;
        checkOutput("t2_fifo_full_cnt", fifo_cnt_o, 4);
        checkOutput("t2_host_ready_full", host_ready_o, 0);
        checkOutput("t2_req_valid", vpu_req_valid_o, 1);
        host_valid_i = 1'b1;
        host_cmd_i   = randCmd();
        host_tag_i   = 4'hF;
        for (int i = 0; i < 10; i++) begin
            checkOutput("t2_stall_valid", vpu_req_valid_o, 1);
            checkOutput("t2_stall_cmd", vpu_req_cmd_o, expQ[0].cmd);
            checkOutput("t2_stall_cnt", fifo_cnt_o, 4);
            tick();
        end
        host_valid_i = 1'b0;
        drain();

        // Completion back-pressure blocks the next issue, which then follows with no idle cycle.
        applyReset();
        hostPush(4'd5);
        hostPush(4'd6);
        hostPush(4'd7);
        host_valid_i = 1'b0;
        checkOutput("t3_cnt_two", fifo_cnt_o, 2);
        vpu_req_ready_i = 1'b1;
        hsCnt++;
        tick();
        vpu_req_ready_i = 1'b0;
        vpu_done_i      = 1'b1;
        tick();
        vpu_done_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("t3_cpl_held", cpl_valid_o, 1);
            checkOutput("t3_cpl_tag", cpl_tag_o, 5);
            checkOutput("t3_no_issue", vpu_req_valid_o, 0);
            checkOutput("t3_cnt_held", fifo_cnt_o, 2);
            tick();
        end
        cpl_ready_i = 1'b1;
        consCnt++;
        tick();
        cpl_ready_i = 1'b0;
        checkOutput("t3_back_to_back_valid", vpu_req_valid_o, 1);
        checkOutput("t3_back_to_back_cmd", vpu_req_cmd_o, expQ[1].cmd);
        checkOutput("t3_cpl_dropped", cpl_valid_o, 0);
        checkOutput("t3_cnt_one", fifo_cnt_o, 1);
        drain();

        // Stray done pulse while idle.
        applyReset();
        vpu_done_i = 1'b1;
        tick();
        vpu_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_err_set", err_o, 1);
            checkOutput("t4_no_cpl", cpl_valid_o, 0);
            checkOutput("t4_idle_busy", busy_o, 0);
            checkOutput("t4_no_req", vpu_req_valid_o, 0);
            tick();
        end
        applyReset();
        checkOutput("t4_err_cleared_by_reset", err_o, 0);

        // Asynchronous reset while a command is outstanding and three are queued.
        for (int i = 0; i < 4; i++) hostPush(4'(8 + i));
        host_valid_i = 1'b0;
        checkOutput("t5_cnt_three", fifo_cnt_o, 3);
        vpu_req_ready_i = 1'b1;
        tick();
        vpu_req_ready_i = 1'b0;
        checkOutput("t5_in_wait", vpu_req_valid_o, 0);
        checkOutput("t5_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_req_valid", vpu_req_valid_o, 0);
        checkOutput("t5_rst_cpl_valid", cpl_valid_o, 0);
        checkOutput("t5_rst_busy", busy_o, 0);
        checkOutput("t5_rst_cnt", fifo_cnt_o, 0);
        checkOutput("t5_rst_host_ready", host_ready_o, 1);
        checkOutput("t5_rst_cmd", vpu_req_cmd_o, 0);
        checkOutput("t5_rst_err", err_o, 0);
        tick();
        rst_n           = 1'b1;
        vpu_req_ready_i = 1'b1;
        cpl_ready_i     = 1'b1;
        for (int i = 0; i < 15; i++) begin
            checkOutput("t5_post_no_cpl", cpl_valid_o, 0);
            checkOutput("t5_post_no_req", vpu_req_valid_o, 0);
            checkOutput("t5_post_cnt", fifo_cnt_o, 0);
            tick();
        end

        // Randomized traffic against the transaction model.
        applyReset();
        for (int i = 0; i < 800; i++) applyStimulus(35, 50, 60);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
